vproc_div_elem_seq: RTL and testbench
=====================================

Name: vproc_div_elem_seq

Overview:
- Element sequencer that sits between the vector DIV pipeline stage and a pool of LANES iterative 32-bit divider lanes.
- Accepts one DIV_OP_W-wide operand pair per transaction and splits it into SEW-sized elements.
- Dispatches one pass of up to LANES elements at a time, sign- or zero-extending each to 32 bits. Elements whose mask is off are never dispatched.
- Reassembles truncated lane results into one packed DIV_OP_W result word and hands it downstream with its opaque tag.

Parameters:
- DIV_OP_W, 64, operand/result width in bits; multiple of 32.
- LANES, 2, number of 32-bit divider lanes; must divide DIV_OP_W/32.
- TAG_W, 8, width of the opaque control tag carried alongside the data.

Ports:
- clk_i  in  1  clock
- async_rst_ni  in  1  reset; asynchronous, active-low
- in_valid_i  in  1  operand word valid
- in_ready_o  out  1  sequencer can accept a word
- in_sew_i  in  2  element width, vproc_pkg vsew encoding (VSEW_8/16/32)
- in_op_i  in  2  div op (DIV_DIVU/DIV_DIV/DIV_REMU/DIV_REM)
- in_dividend_i  in  DIV_OP_W  dividend elements
- in_divisor_i  in  DIV_OP_W  divisor elements
- in_mask_i  in  DIV_OP_W/8  byte mask
- in_tag_i  in  TAG_W  opaque tag
- lane_valid_o  out  LANES  per-lane issue valid
- lane_ready_i  in  LANES  per-lane issue ready
- lane_op_o  out  2  op, shared by all lanes
- lane_opa_o  out  32*LANES  extended dividends
- lane_opb_o  out  32*LANES  extended divisors
- lane_res_valid_i  in  LANES  per-lane result valid
- lane_res_i  in  32*LANES  lane results
- lane_res_ready_o  out  LANES  per-lane result ready
- out_valid_o  out  1  result word valid
- out_ready_i  in  1  downstream ready
- out_res_o  out  DIV_OP_W  packed result
- out_mask_o  out  DIV_OP_W/8  latched in_mask
- out_tag_o  out  TAG_W  latched tag

Behaviour:
- Reset (async, active-low) values:
  - in_ready_o=1
  - lane_valid_o=0, lane_res_ready_o=0
  - out_valid_o=0, out_res_o=0, out_mask_o=0, out_tag_o=0
  - state IDLE; pass counter 0; issued/returned flags 0
- Reset mid-operation abandons the word. Late lane results are not consumed. The lanes are expected to share the same reset.
- Element geometry:
  - E = DIV_OP_W/SEW elements per word.
  - P = E/LANES passes per word.
  - Pass p covers elements p*LANES+l for l = 0..LANES-1.
- Element activity: an element is active iff the mask bit of its lowest byte is 1.
- Operand extension:
  - DIV/REM: sign-extend to 32 bits.
  - DIVU/REMU: zero-extend to 32 bits.
  - Inactive lanes drive opa=opb=0.
- Result packing: the low SEW bits of the lane result are written to the element slot. Inactive element slots are 0.
- FSM states: IDLE, ISSUE, WAIT, OUT.
  - IDLE: in_ready_o=1. On in_valid_i, latch all inputs, clear the result buffer, set pass=0, go to ISSUE. Latency from handshake to first lane_valid is 1 cycle.
  - ISSUE: assert lane_valid_o[l] for each active, not-yet-issued lane. A lane's issued flag sets on valid&ready, and its valid drops the next cycle. Lanes are accepted independently in any order. Go to WAIT once all active lanes are issued.
    - A pass with zero active elements spends exactly 1 cycle in ISSUE, then advances the pass (or goes to OUT if it is the last pass) without any lane traffic.
  - WAIT: lane_res_ready_o[l]=1 for issued, not-yet-returned lanes; 0 for all other lanes. On res_valid&ready, write the slot and set the returned flag. When all issued lanes have returned: if pass==P-1 go to OUT, else pass+1, clear flags, go to ISSUE.
    - Issue of pass p+1 never overlaps collection of pass p.
  - OUT: out_valid_o=1. Outputs hold stable until out_ready_i; on the handshake go to IDLE. in_ready_o=0 in OUT, giving a 1-cycle bubble per word.
- A result valid on a lane not in the issued-and-outstanding set is ignored and not acknowledged.
- lane_op_o and lane operands stay stable while the corresponding valid is high.
- SEW encodings other than 8/16/32 are treated as SEW32.

Decomposition:
- vproc_pkg holds:
  - vsew encoding and div op enum (existing);
  - new typedef div_seq_state_e {IDLE, ISSUE, WAIT, OUT}.
- One natural sub-module: vproc_div_elem_extract. It is combinational: given sew, op, pass index and the latched words, it produces per-lane extended operands and the active vector. It also provides the inverse slot-write enables.
- FSM, flags and result buffer stay in the top module.

Test Plan:
- SEW32 DIVU, full mask: dividend {100,7}, divisor {10,2} -> one pass, both lanes issued in the same cycle, out_res={10,3}, out_mask=0xFF.
- SEW8 DIV: all dividend bytes 0xF8 (-8), divisor bytes 0x02 -> 4 passes, lane opa=0xFFFFFFF8, every result byte 0xFC. Signed REM with dividend 0x07 and divisor 0x02 -> 0x01.
- SEW16 DIVU, mask 8'b00110011 -> exactly 2 lane issue handshakes (elements 0 and 2). Result halfwords 1 and 3 are 0x0000; out_mask=0x33.
- Mask 0x00, SEW8 -> zero lane handshakes, out_valid after 1+4 cycles, out_res=0.
- Backpressure: lane_ready_i[1] low for 5 cycles while lane 0 is accepted at once -> lane_valid_o[0] drops after its handshake, lane_valid_o[1] is held with stable operands. Then hold out_ready_i low for 3 cycles -> out_res_o stays stable and in_ready_o=0.
- Assert reset in WAIT of pass 1 (SEW16) -> all outputs go to reset values at once, in_ready_o=1; a fresh word then completes correctly.

Source files
------------

// File: rtl/vproc_pkg.sv
// Shared vector-processor encodings plus the element-sequencer state type.
// sew_bytes() maps any non-8/16 SEW code onto 32-bit elements.
package vproc_pkg;

  typedef enum logic [1:0] {
    VSEW_8       = 2'b00,
    VSEW_16      = 2'b01,
    VSEW_32      = 2'b10,
    VSEW_INVALID = 2'b11
  } vsew_e;

  typedef enum logic [1:0] {
    DIV_DIVU = 2'b00,
    DIV_DIV  = 2'b01,
    DIV_REMU = 2'b10,
    DIV_REM  = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    OUT   = 2'b11
  } div_seq_state_e;

  function automatic int sew_bytes(vsew_e sew);
    case (sew)
      VSEW_8:  return 1;
      VSEW_16: return 2;
      default: return 4;
    endcase
  endfunction

endpackage

// File: rtl/vproc_div_elem_extract.sv
// Combinational element slicer: per-lane extended operands and activity for one pass,
// plus the slot masks/data that put truncated lane results back into the packed word.
module vproc_div_elem_extract import vproc_pkg::*; #(
  parameter int DIV_OP_W = 64,
  parameter int LANES    = 2,
  parameter int PASS_W   = 2
) (
  input  vsew_e                       sew_i,
  input  div_op_e                     op_i,
  input  logic [PASS_W-1:0]           pass_i,
  input  logic [DIV_OP_W-1:0]         dividend_i,
  input  logic [DIV_OP_W-1:0]         divisor_i,
  input  logic [DIV_OP_W/8-1:0]       mask_i,
  input  logic [32*LANES-1:0]         lane_res_i,
  output logic [32*LANES-1:0]         opa_o,
  output logic [32*LANES-1:0]         opb_o,
  output logic [LANES-1:0]            active_o,
  output logic [LANES*DIV_OP_W-1:0]   slot_wmask_o,
  output logic [LANES*DIV_OP_W-1:0]   slot_wdata_o
);

  localparam int NBYTES = DIV_OP_W / 8;

  logic sgn;
  assign sgn = (op_i == DIV_DIV) || (op_i == DIV_REM);

  function automatic logic [31:0] ext32(logic [31:0] raw, int nb, logic is_signed);
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    s8  = raw[7:0];
    s16 = raw[15:0];
    case (nb)
      1:       return is_signed ? 32'(s8)  : {24'b0, raw[7:0]};
      2:       return is_signed ? 32'(s16) : {16'b0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  always_comb begin
    opa_o        = '0;
    opb_o        = '0;
    active_o     = '0;
    slot_wmask_o = '0;
    slot_wdata_o = '0;
    for (int l = 0; l < LANES; l++) begin
      automatic int                  nb;
      automatic int                  off;
      automatic logic [31:0]         raw_a;
      automatic logic [31:0]         raw_b;
      automatic logic [DIV_OP_W-1:0] wmask;
      automatic logic [DIV_OP_W-1:0] wdata;
      nb    = sew_bytes(sew_i);
      off   = (int'(pass_i) * LANES + l) * nb;
      raw_a = '0;
      raw_b = '0;
      wmask = '0;
      wdata = '0;
      // Element slot is identified by its lowest byte; its mask bit decides activity.
      if (off + nb <= NBYTES) begin
        case (nb)
          1: begin
            raw_a = {24'b0, dividend_i[off*8 +: 8]};
            raw_b = {24'b0, divisor_i[off*8 +: 8]};
            wmask[off*8 +: 8] = '1;
            wdata[off*8 +: 8] = lane_res_i[l*32 +: 8];
          end
          2: begin
            raw_a = {16'b0, dividend_i[off*8 +: 16]};
            raw_b = {16'b0, divisor_i[off*8 +: 16]};
            wmask[off*8 +: 16] = '1;
            wdata[off*8 +: 16] = lane_res_i[l*32 +: 16];
          end
          default: begin
            raw_a = dividend_i[off*8 +: 32];
            raw_b = divisor_i[off*8 +: 32];
            wmask[off*8 +: 32] = '1;
            wdata[off*8 +: 32] = lane_res_i[l*32 +: 32];
          end
        endcase
        if (mask_i[off]) begin
          active_o[l]                            = 1'b1;
          opa_o[l*32 +: 32]                      = ext32(raw_a, nb, sgn);
          opb_o[l*32 +: 32]                      = ext32(raw_b, nb, sgn);
          slot_wmask_o[l*DIV_OP_W +: DIV_OP_W]   = wmask;
          slot_wdata_o[l*DIV_OP_W +: DIV_OP_W]   = wdata;
        end
      end
    end
  end

endmodule

// File: rtl/vproc_div_elem_seq.sv
// Splits a DIV operand word into SEW elements, issues them pass by pass to LANES
// iterative dividers and reassembles the packed result with its tag.
module vproc_div_elem_seq import vproc_pkg::*; #(
  parameter int DIV_OP_W = 64,
  parameter int LANES    = 2,
  parameter int TAG_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   async_rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [1:0]             in_sew_i,
  input  logic [1:0]             in_op_i,
  input  logic [DIV_OP_W-1:0]    in_dividend_i,
  input  logic [DIV_OP_W-1:0]    in_divisor_i,
  input  logic [DIV_OP_W/8-1:0]  in_mask_i,
  input  logic [TAG_W-1:0]       in_tag_i,
  output logic [LANES-1:0]       lane_valid_o,
  input  logic [LANES-1:0]       lane_ready_i,
  output logic [1:0]             lane_op_o,
  output logic [32*LANES-1:0]    lane_opa_o,
  output logic [32*LANES-1:0]    lane_opb_o,
  input  logic [LANES-1:0]       lane_res_valid_i,
  input  logic [32*LANES-1:0]    lane_res_i,
  output logic [LANES-1:0]       lane_res_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DIV_OP_W-1:0]    out_res_o,
  output logic [DIV_OP_W/8-1:0]  out_mask_o,
  output logic [TAG_W-1:0]       out_tag_o
);

  localparam int NBYTES = DIV_OP_W / 8;
  localparam int MAX_P  = NBYTES / LANES;
  localparam int PASS_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;

  div_seq_state_e          state_q, state_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [LANES-1:0]        issued_q, issued_d;
  logic [LANES-1:0]        returned_q, returned_d;
  logic [DIV_OP_W-1:0]     res_q, res_d;
  logic [NBYTES-1:0]       mask_q, mask_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  vsew_e                   sew_q;
  div_op_e                 op_q;
  logic [DIV_OP_W-1:0]     dvd_q, dvs_q;

  logic                    accept;
  logic                    last_pass;
  logic [LANES-1:0]        active;
  logic [LANES-1:0]        issue_hs;
  logic [LANES-1:0]        res_hs;
  logic                    all_issued;
  logic                    all_returned;
  logic [LANES*DIV_OP_W-1:0] slot_wmask;
  logic [LANES*DIV_OP_W-1:0] slot_wdata;

  vproc_div_elem_extract #(
    .DIV_OP_W (DIV_OP_W),
    .LANES    (LANES),
    .PASS_W   (PASS_W)
  ) u_extract (
    .sew_i        (sew_q),
    .op_i         (op_q),
    .pass_i       (pass_q),
    .dividend_i   (dvd_q),
    .divisor_i    (dvs_q),
    .mask_i       (mask_q),
    .lane_res_i   (lane_res_i),
    .opa_o        (lane_opa_o),
    .opb_o        (lane_opb_o),
    .active_o     (active),
    .slot_wmask_o (slot_wmask),
    .slot_wdata_o (slot_wdata)
  );

  assign accept       = in_valid_i && (state_q == IDLE);
  assign last_pass    = (int'(pass_q) == (NBYTES / (sew_bytes(sew_q) * LANES)) - 1);
  assign issue_hs     = lane_valid_o & lane_ready_i;
  assign res_hs       = lane_res_valid_i & lane_res_ready_o;
  assign all_issued   = (((issued_q | issue_hs) & active) == active);
  assign all_returned = ((returned_q | res_hs) == issued_q);
  assign lane_op_o    = op_q;
  assign out_res_o    = res_q;
  assign out_mask_o   = mask_q;
  assign out_tag_o    = tag_q;

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (in_valid_i) state_d = ISSUE;
      ISSUE: begin
        // A pass with no active elements still costs one ISSUE cycle.
        if (all_issued) begin
          if (active == '0) state_d = last_pass ? OUT : ISSUE;
          else              state_d = WAIT;
        end
      end
      WAIT:  if (all_returned) state_d = last_pass ? OUT : ISSUE;
      OUT:   if (out_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o       = (state_q == IDLE);
    lane_valid_o     = (state_q == ISSUE) ? (active & ~issued_q) : '0;
    lane_res_ready_o = (state_q == WAIT) ? (issued_q & ~returned_q) : '0;
    out_valid_o      = (state_q == OUT);
  end

  always_comb begin
    pass_d     = pass_q;
    issued_d   = issued_q;
    returned_d = returned_q;
    res_d      = res_q;
    mask_d     = accept ? in_mask_i : mask_q;
    tag_d      = accept ? in_tag_i  : tag_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          pass_d     = '0;
          issued_d   = '0;
          returned_d = '0;
          res_d      = '0;
        end
      end
      ISSUE: begin
        issued_d = issued_q | issue_hs;
        if (all_issued && (active == '0) && !last_pass) pass_d = pass_q + 1'b1;
      end
      WAIT: begin
        returned_d = returned_q | res_hs;
        for (int l = 0; l < LANES; l++) begin
          if (res_hs[l]) begin
            res_d = (res_d & ~slot_wmask[l*DIV_OP_W +: DIV_OP_W]) | slot_wdata[l*DIV_OP_W +: DIV_OP_W];
          end
        end
        if (all_returned) begin
          issued_d   = '0;
          returned_d = '0;
          if (!last_pass) pass_d = pass_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge async_rst_ni) begin
    if (!async_rst_ni) begin
      pass_q     <= '0;
      issued_q   <= '0;
      returned_q <= '0;
      res_q      <= '0;
      mask_q     <= '0;
      tag_q      <= '0;
    end else begin
      pass_q     <= pass_d;
      issued_q   <= issued_d;
      returned_q <= returned_d;
      res_q      <= res_d;
      mask_q     <= mask_d;
      tag_q      <= tag_d;
    end
  end

  // Operand words are only meaningful outside IDLE, so they carry no reset.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      sew_q <= vsew_e'(in_sew_i);
      op_q  <= div_op_e'(in_op_i);
      dvd_q <= in_dividend_i;
      dvs_q <= in_divisor_i;
    end
  end

endmodule

// File: tb/tb_vproc_div_elem_seq.sv
// Directed bench for vproc_div_elem_seq with a small behavioural divider-lane pool.
module tb_vproc_div_elem_seq;
  import vproc_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [1:0]  in_sew, in_op;
  logic [63:0] dvd, dvs;
  logic [7:0]  mask, tag;
  logic [1:0]  lane_valid, lane_ready, lane_op;
  logic [63:0] lane_opa, lane_opb;
  logic [1:0]  lane_res_valid, lane_res_ready;
  logic [63:0] lane_res;
  logic        out_valid, out_ready;
  logic [63:0] out_res;
  logic [7:0]  out_mask, out_tag;

  int checks;
  int errors;

  logic [1:0] pend;
  logic       res_en;
  logic [1:0] spur;
  int         iss_cnt;

  assign lane_res_valid = (pend & {2{res_en}}) | spur;

  vproc_div_elem_seq #(.DIV_OP_W(64), .LANES(2), .TAG_W(8)) dut (
    .clk_i            (clk),
    .async_rst_ni     (rst_n),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_sew_i         (in_sew),
    .in_op_i          (in_op),
    .in_dividend_i    (dvd),
    .in_divisor_i     (dvs),
    .in_mask_i        (mask),
    .in_tag_i         (tag),
    .lane_valid_o     (lane_valid),
    .lane_ready_i     (lane_ready),
    .lane_op_o        (lane_op),
    .lane_opa_o       (lane_opa),
    .lane_opb_o       (lane_opb),
    .lane_res_valid_i (lane_res_valid),
    .lane_res_i       (lane_res),
    .lane_res_ready_o (lane_res_ready),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_res_o        (out_res),
    .out_mask_o       (out_mask),
    .out_tag_o        (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] lane_div(logic [1:0] op, logic [31:0] a, logic [31:0] b);
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      DIV_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      DIV_REMU: return (b == 0) ? a : a % b;
      DIV_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      default:  return (b == 0) ? a : (ovf ? 32'h0 : 32'($signed(a) % $signed(b)));
    endcase
  endfunction

  // Divider lanes: accept on valid&ready, present the result one cycle later.
  always begin : lane_model
    logic [1:0]  s_iss, s_ret;
    logic [63:0] s_a, s_b;
    logic [1:0]  s_op;
    @(negedge clk);
    s_iss = lane_valid & lane_ready;
    s_ret = lane_res_valid & lane_res_ready;
    s_a   = lane_opa;
    s_b   = lane_opb;
    s_op  = lane_op;
    @(posedge clk);
    #1;
    for (int l = 0; l < 2; l++) begin
      if (s_ret[l]) pend[l] = 1'b0;
      if (s_iss[l]) begin
        lane_res[l*32 +: 32] = lane_div(s_op, s_a[l*32 +: 32], s_b[l*32 +: 32]);
        pend[l] = 1'b1;
        iss_cnt++;
      end
    end
  end

  task automatic send_word(input logic [1:0] sew, input logic [1:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [7:0] m, input logic [7:0] t);
    in_sew   = sew;
    in_op    = op;
    dvd      = a;
    dvs      = b;
    mask     = m;
    tag      = t;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++;
    if ({lane_valid, lane_res_ready} !== 4'b0) begin
      errors++; $display("FAIL rst_lane_ctl got %b want 0000", {lane_valid, lane_res_ready});
    end
    checks++;
    if (out_valid !== 1'b0 || out_res !== 64'h0 || out_mask !== 8'h0 || out_tag !== 8'h0) begin
      errors++; $display("FAIL rst_out got v=%b res=%h m=%h t=%h want all 0", out_valid, out_res, out_mask, out_tag);
    end
  endtask

  task automatic test_sew32_divu();
    int n;
    int c0;
    c0 = iss_cnt;
    send_word(VSEW_32, DIV_DIVU, {32'd100, 32'd7}, {32'd10, 32'd2}, 8'hFF, 8'hA1);
    checks++;
    if (lane_valid !== 2'b11) begin errors++; $display("FAIL s32_first_issue got %b want 11", lane_valid); end
    checks++;
    if (lane_opa !== {32'd100, 32'd7}) begin errors++; $display("FAIL s32_opa got %h want %h", lane_opa, {32'd100, 32'd7}); end
    wait_out(20, n);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL s32_latency got %0d want 2", n); end
    checks++;
    if (out_res !== {32'd10, 32'd3}) begin errors++; $display("FAIL s32_res got %h want %h", out_res, {32'd10, 32'd3}); end
    checks++;
    if (out_mask !== 8'hFF || out_tag !== 8'hA1) begin
      errors++; $display("FAIL s32_mask_tag got %h/%h want ff/a1", out_mask, out_tag);
    end
    checks++;
    if (iss_cnt - c0 !== 2) begin errors++; $display("FAIL s32_issues got %0d want 2", iss_cnt - c0); end
    finish_out();
  endtask

  task automatic test_sew8();
    int n;
    int c0;
    c0 = iss_cnt;
    send_word(VSEW_8, DIV_DIV, {8{8'hF8}}, {8{8'h02}}, 8'hFF, 8'h08);
    checks++;
    if (lane_opa !== {2{32'hFFFF_FFF8}} || lane_opb !== {2{32'h0000_0002}}) begin
      errors++; $display("FAIL s8_signext got %h/%h want fffffff8 x2 / 00000002 x2", lane_opa, lane_opb);
    end
    wait_out(40, n);
    checks++;
    if (out_res !== {8{8'hFC}}) begin errors++; $display("FAIL s8_div_res got %h want %h", out_res, {8{8'hFC}}); end
    checks++;
    if (iss_cnt - c0 !== 8) begin errors++; $display("FAIL s8_issues got %0d want 8", iss_cnt - c0); end
    finish_out();

    send_word(VSEW_8, DIV_REM, {8{8'h07}}, {8{8'h02}}, 8'hFF, 8'h09);
    wait_out(40, n);
    checks++;
    if (out_res !== {8{8'h01}}) begin errors++; $display("FAIL s8_rem_res got %h want %h", out_res, {8{8'h01}}); end
    finish_out();

    send_word(VSEW_8, DIV_DIVU, {8{8'hF8}}, {8{8'h02}}, 8'hFF, 8'h0A);
    checks++;
    if (lane_opa !== {2{32'h0000_00F8}}) begin
      errors++; $display("FAIL s8_zeroext got %h want %h", lane_opa, {2{32'h0000_00F8}});
    end
    wait_out(40, n);
    checks++;
    if (out_res !== {8{8'h7C}}) begin errors++; $display("FAIL s8_divu_res got %h want %h", out_res, {8{8'h7C}}); end
    finish_out();
  endtask

  task automatic test_sew16_mask();
    int n;
    int c0;
    logic seen1;
    c0    = iss_cnt;
    seen1 = 1'b0;
    spur  = 2'b10;
    send_word(VSEW_16, DIV_DIVU, 64'h0004_0030_0009_0064, 64'h0002_0005_0003_000A, 8'h33, 8'h16);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      if (lane_valid[1] || lane_res_ready[1]) seen1 = 1'b1;
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = i;
        break;
      end
    end
    spur = 2'b00;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL s16_latency got %0d want 4", n); end
    checks++;
    if (out_res !== 64'h0000_0009_0000_000A) begin
      errors++; $display("FAIL s16_res got %h want 000000090000000a", out_res);
    end
    checks++;
    if (out_mask !== 8'h33) begin errors++; $display("FAIL s16_mask got %h want 33", out_mask); end
    checks++;
    if (iss_cnt - c0 !== 2) begin errors++; $display("FAIL s16_issues got %0d want 2", iss_cnt - c0); end
    checks++;
    if (seen1 !== 1'b0) begin errors++; $display("FAIL s16_spurious_lane1 got %b want 0", seen1); end
    finish_out();
  endtask

  task automatic test_zero_mask();
    int n;
    int c0;
    c0 = iss_cnt;
    send_word(VSEW_8, DIV_DIVU, 64'h1122_3344_5566_7788, {8{8'h03}}, 8'h00, 8'h00);
    wait_out(20, n);
    // Handshake cycle + 4 empty ISSUE cycles: out_valid four edges after acceptance.
    checks++;
    if (n !== 4) begin errors++; $display("FAIL zm_latency got %0d want 4", n); end
    checks++;
    if (out_res !== 64'h0) begin errors++; $display("FAIL zm_res got %h want 0", out_res); end
    checks++;
    if (iss_cnt - c0 !== 0) begin errors++; $display("FAIL zm_issues got %0d want 0", iss_cnt - c0); end
    finish_out();
  endtask

  task automatic test_backpressure();
    int n;
    lane_ready = 2'b01;
    send_word(VSEW_32, DIV_REMU, {32'd50, 32'd9}, {32'd7, 32'd3}, 8'hFF, 8'h5B);
    checks++;
    if (lane_valid !== 2'b11) begin errors++; $display("FAIL bp_first got %b want 11", lane_valid); end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (lane_valid !== 2'b10 || lane_opa[63:32] !== 32'd50 || lane_opb[63:32] !== 32'd7 || lane_op !== DIV_REMU) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got v=%b a=%h b=%h op=%0d want 10/32/7/2", i, lane_valid, lane_opa[63:32], lane_opb[63:32], lane_op);
      end
    end
    lane_ready = 2'b11;
    wait_out(20, n);
    checks++;
    if (out_valid !== 1'b1 || out_res !== {32'd1, 32'd0}) begin
      errors++; $display("FAIL bp_res got v=%b res=%h want 1 %h", out_valid, out_res, {32'd1, 32'd0});
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_res !== {32'd1, 32'd0} || out_tag !== 8'h5B) begin
        errors++; $display("FAIL bp_out_hold cyc %0d got v=%b rdy=%b res=%h t=%h", i, out_valid, in_ready, out_res, out_tag);
      end
    end
    finish_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_after_out got rdy=%b v=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_midop();
    int n;
    send_word(VSEW_16, DIV_DIV, 64'hFFF0_0064_0015_FF9C, 64'h0004_0007_0003_000A, 8'hFF, 8'h77);
    checks++;
    if (lane_opa !== {32'h0000_0015, 32'hFFFF_FF9C}) begin
      errors++; $display("FAIL rm_p0_opa got %h want 00000015ffffff9c", lane_opa);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    res_en = 1'b0;
    checks++;
    if (lane_res_ready !== 2'b11 || lane_opa !== {32'hFFFF_FFF0, 32'h0000_0064}) begin
      errors++; $display("FAIL rm_in_wait_p1 got rr=%b opa=%h want 11 fffffff000000064", lane_res_ready, lane_opa);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || lane_valid !== 2'b00 || lane_res_ready !== 2'b00 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rm_ctl got rdy=%b lv=%b rr=%b ov=%b", in_ready, lane_valid, lane_res_ready, out_valid);
    end
    checks++;
    if (out_res !== 64'h0 || out_mask !== 8'h0 || out_tag !== 8'h0) begin
      errors++; $display("FAIL rm_data got res=%h m=%h t=%h want 0", out_res, out_mask, out_tag);
    end
    pend = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    res_en = 1'b1;
    @(posedge clk); #1;
    send_word(VSEW_16, DIV_DIV, 64'hFFF0_0064_0015_FF9C, 64'h0004_0007_0003_000A, 8'hFF, 8'h66);
    wait_out(30, n);
    checks++;
    if (out_res !== 64'hFFFC_000E_0007_FFF6 || out_tag !== 8'h66) begin
      errors++; $display("FAIL rm_fresh got res=%h t=%h want fffc000e0007fff6 66", out_res, out_tag);
    end
    finish_out();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pend       = 2'b00;
    res_en     = 1'b1;
    spur       = 2'b00;
    iss_cnt    = 0;
    lane_res   = '0;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_sew     = 2'b00;
    in_op      = 2'b00;
    dvd        = '0;
    dvs        = '0;
    mask       = '0;
    tag        = '0;
    lane_ready = 2'b11;
    out_ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_sew32_divu();
    test_sew8();
    test_sew16_mask();
    test_zero_mask();
    test_backpressure();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
